p10_nanov_spi_ram: RTL and testbench

- Synchronous SPI memory responder: the far end of the nanoV SPI master link.
- Decodes 23LC-style READ (0x03) and WRITE (0x02) commands with a 24-bit address.
- Streams bytes from, or stores bytes into, an internal byte array.
- Clocked by the same clk as the CPU: one SPI bit per clk edge while selected and clock-enabled. Used as on-die program/data RAM and as the bench memory model.

---
 rtl/p10_nanov_spi_ram.sv | 190 +++++++++++++++++++
 tb/tb_p10_nanov_spi_ram.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/p10_nanov_spi_ram.sv
// p10_nanov_spi_ram: SPI memory responder on the CPU clock (one bit per active clk).
// Decodes READ (0x03) and WRITE (0x02) with a 24-bit MSB-first address over an
// internal byte array, plus a backdoor byte-load port.
// Optional: define P10_NANOV_SPI_RAM_FAST_READ_EN to accept FAST READ (0x0B),
// which inserts 8 dummy cycles before the first data bit.
// Handshake: a cycle is "active" when spi_select==0 && spi_clk_enable==1; only
// active cycles advance SPI state. spi_select==1 aborts and returns to CMD.
module p10_nanov_spi_ram #(
  parameter int MEM_ADDR_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     spi_select,
  input  logic                     spi_clk_enable,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  input  logic                     load_en,
  input  logic [MEM_ADDR_BITS-1:0] load_addr,
  input  logic [7:0]               load_data,
  output logic                     busy
);

  localparam int DEPTH = 1 << MEM_ADDR_BITS;

  typedef enum logic [2:0] {
    S_CMD, S_ADDR, S_DUMMY, S_READ, S_WRITE, S_IGNORE
  } state_t;

  logic [7:0] mem [0:DEPTH-1];

  state_t                   state, state_n;
  logic [4:0]               cnt, cnt_n;
  logic [7:0]               sh, sh_n;
  logic [7:0]               rd, rd_n;
  logic [MEM_ADDR_BITS-1:0] addr, addr_n;
  logic                     is_write, is_write_n;
  logic                     is_fast, is_fast_n;
  logic                     miso_q, miso_n;
  logic                     busy_q, busy_n;
  logic                     wr_en;
  logic [7:0]               wr_data;

  logic [7:0]               sh_in;
  logic [MEM_ADDR_BITS-1:0] addr_in, addr_inc, fetch_addr;
  logic [7:0]               fetch_byte;

  assign sh_in      = {sh[6:0], spi_mosi};
  assign addr_in    = {addr[MEM_ADDR_BITS-2:0], spi_mosi};
  assign addr_inc   = addr + 1'b1;
  assign fetch_byte = mem[fetch_addr];
  assign spi_miso   = miso_q;
  assign busy       = busy_q;

  // Select which byte a fetch would load: the freshly shifted address at the end
  // of ADDR, the next byte while streaming, the held address after DUMMY.
  always_comb begin
    fetch_addr = addr;
    if (state == S_ADDR)      fetch_addr = addr_in;
    else if (state == S_READ) fetch_addr = addr_inc;
  end

  // Next-state, datapath and output decode for one active SPI bit.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    sh_n       = sh;
    rd_n       = rd;
    addr_n     = addr;
    is_write_n = is_write;
    is_fast_n  = is_fast;
    miso_n     = miso_q;
    wr_en      = 1'b0;
    wr_data    = sh_in;
    if (spi_select) begin
      state_n = S_CMD;
      cnt_n   = 5'd0;
      miso_n  = 1'b0;
    end else if (spi_clk_enable) begin
      case (state)
        S_CMD: begin
          sh_n  = sh_in;
          cnt_n = cnt + 5'd1;
          if (cnt == 5'd7) begin
            cnt_n      = 5'd0;
            is_write_n = 1'b0;
            is_fast_n  = 1'b0;
            case (sh_in)
              8'h03: state_n = S_ADDR;
              8'h02: begin
                state_n    = S_ADDR;
                is_write_n = 1'b1;
              end
`ifdef P10_NANOV_SPI_RAM_FAST_READ_EN
              8'h0B: begin
                state_n   = S_ADDR;
                is_fast_n = 1'b1;
              end
`endif
              default: state_n = S_IGNORE;
            endcase
          end
        end
        S_ADDR: begin
          addr_n = addr_in;
          cnt_n  = cnt + 5'd1;
          if (cnt == 5'd23) begin
            cnt_n = 5'd0;
            if (is_write) begin
              state_n = S_WRITE;
            end else if (is_fast) begin
              state_n = S_DUMMY;
            end else begin
              state_n = S_READ;
              miso_n  = fetch_byte[7];
              rd_n    = {fetch_byte[6:0], 1'b0};
              cnt_n   = 5'd1;
            end
          end
        end
        S_DUMMY: begin
          miso_n = 1'b0;
          cnt_n  = cnt + 5'd1;
          if (cnt == 5'd7) begin
            state_n = S_READ;
            miso_n  = fetch_byte[7];
            rd_n    = {fetch_byte[6:0], 1'b0};
            cnt_n   = 5'd1;
          end
        end
        S_READ: begin
          if (cnt == 5'd8) begin
            addr_n = addr_inc;
            miso_n = fetch_byte[7];
            rd_n   = {fetch_byte[6:0], 1'b0};
            cnt_n  = 5'd1;
          end else begin
            miso_n = rd[7];
            rd_n   = {rd[6:0], 1'b0};
            cnt_n  = cnt + 5'd1;
          end
        end
        S_WRITE: begin
          miso_n = 1'b0;
          sh_n   = sh_in;
          cnt_n  = cnt + 5'd1;
          if (cnt == 5'd7) begin
            wr_en  = 1'b1;
            addr_n = addr_inc;
            cnt_n  = 5'd0;
          end
        end
        default: miso_n = 1'b0;
      endcase
    end
    busy_n = (state_n == S_ADDR) || (state_n == S_DUMMY) ||
             (state_n == S_READ) || (state_n == S_WRITE);
  end

  // SPI state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= S_CMD;
      cnt      <= 5'd0;
      sh       <= 8'd0;
      rd       <= 8'd0;
      addr     <= '0;
      is_write <= 1'b0;
      is_fast  <= 1'b0;
      miso_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sh       <= sh_n;
      rd       <= rd_n;
      addr     <= addr_n;
      is_write <= is_write_n;
      is_fast  <= is_fast_n;
      miso_q   <= miso_n;
      busy_q   <= busy_n;
    end
  end

  // Memory array (never reset); the backdoor load is written last so it wins a same-address clash.
  always_ff @(posedge clk) begin
    if (wr_en && rstn) mem[addr] <= wr_data;
    if (load_en)       mem[load_addr] <= load_data;
  end

endmodule

// File: tb/tb_p10_nanov_spi_ram.sv
// Directed bench for p10_nanov_spi_ram: reset, read, write with wrap, pause,
// aborted write, ignored command, fast read (macro-dependent), load collision.
module tb_p10_nanov_spi_ram;

  logic       clk;
  logic       rstn;
  logic       spi_select;
  logic       spi_clk_enable;
  logic       spi_mosi;
  logic       spi_miso;
  logic       load_en;
  logic [7:0] load_addr;
  logic [7:0] load_data;
  logic       busy;

  int total = 0;
  int bad   = 0;
  logic [63:0] rx;

  p10_nanov_spi_ram #(.MEM_ADDR_BITS(8)) dut (
    .clk(clk), .rstn(rstn), .spi_select(spi_select), .spi_clk_enable(spi_clk_enable),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .busy(busy)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic spi_bit(input logic b);
    spi_select = 1'b0; spi_clk_enable = 1'b1; spi_mosi = b;
    @(posedge clk); #1;
    rx = {rx[62:0], spi_miso};
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 23; i >= 0; i--) spi_bit(a[i]);
  endtask

  task automatic deselect();
    spi_select = 1'b1; spi_clk_enable = 1'b0; spi_mosi = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (spi_miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b exp=0", spi_miso); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rstn = 1'b1;
    load(8'h10, 8'hA5);
    rstn = 1'b0; @(posedge clk); #1; rstn = 1'b1; @(posedge clk); #1;
    send_byte(8'h03);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_cmd got=%b exp=1", busy); end
    send_addr(24'h000010);
    repeat (7) spi_bit(1'b0);
    total++;
    if (rx[7:0] !== 8'hA5) begin bad++; $display("FAIL mem_survives_reset got=%h exp=a5", rx[7:0]); end
    deselect();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL busy_after_deselect got=%b exp=0", busy); end
  endtask

  task automatic test_read();
    load(8'h20, 8'h3C);
    load(8'h21, 8'hC3);
    send_byte(8'h03);
    send_addr(24'h000020);
    repeat (16) spi_bit(1'b0);
    total++;
    if (rx[16:1] !== 16'h3CC3) begin bad++; $display("FAIL read_stream got=%h exp=3cc3", rx[16:1]); end
    total++;
    if (rx[17] !== 1'b0) begin bad++; $display("FAIL read_latency got=%b exp=0", rx[17]); end
    deselect();
  endtask

  task automatic test_write_wrap();
    send_byte(8'h02);
    send_addr(24'h0000FF);
    send_byte(8'h11);
    total++;
    if (busy !== 1'b1 || spi_miso !== 1'b0) begin
      bad++; $display("FAIL write_busy_miso got=%b%b exp=10", busy, spi_miso);
    end
    send_byte(8'h22);
    deselect();
    send_byte(8'h03);
    send_addr(24'h0000FF);
    repeat (15) spi_bit(1'b0);
    total++;
    if (rx[15:0] !== 16'h1122) begin bad++; $display("FAIL write_wrap got=%h exp=1122", rx[15:0]); end
    deselect();
  endtask

  task automatic test_pause();
    load(8'h40, 8'h81);
    send_byte(8'h03);
    send_addr(24'h000040);
    repeat (4) spi_bit(1'b0);
    spi_clk_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (spi_miso !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL pause_hold cyc=%0d got=%b%b exp=01", i, spi_miso, busy);
      end
    end
    repeat (3) spi_bit(1'b0);
    total++;
    if (rx[7:0] !== 8'h81) begin bad++; $display("FAIL pause_byte got=%h exp=81", rx[7:0]); end
    deselect();
  endtask

  task automatic test_abort_and_ignore();
    load(8'h50, 8'h5A);
    send_byte(8'h02);
    send_addr(24'h000050);
    repeat (4) spi_bit(1'b1);
    deselect();
    send_byte(8'h03);
    send_addr(24'h000050);
    repeat (7) spi_bit(1'b0);
    total++;
    if (rx[7:0] !== 8'h5A) begin bad++; $display("FAIL abort_write got=%h exp=5a", rx[7:0]); end
    deselect();
    send_byte(8'h9F);
    repeat (8) spi_bit(1'b1);
    total++;
    if (rx[15:0] !== 16'h0000 || busy !== 1'b0) begin
      bad++; $display("FAIL ignore_cmd got=%h/%b exp=0000/0", rx[15:0], busy);
    end
    deselect();
    send_byte(8'h03);
    send_addr(24'h000020);
    repeat (7) spi_bit(1'b0);
    total++;
    if (rx[7:0] !== 8'h3C) begin bad++; $display("FAIL after_ignore got=%h exp=3c", rx[7:0]); end
    deselect();
  endtask

  task automatic test_fast_read();
    send_byte(8'h0B);
    send_addr(24'h000020);
    repeat (8) spi_bit(1'b0);
    repeat (7) spi_bit(1'b0);
`ifdef P10_NANOV_SPI_RAM_FAST_READ_EN
    total++;
    if (rx[7:0] !== 8'h3C) begin bad++; $display("FAIL fast_read_data got=%h exp=3c", rx[7:0]); end
    total++;
    if (rx[15:8] !== 8'h00) begin bad++; $display("FAIL fast_read_dummy got=%h exp=00", rx[15:8]); end
`else
    total++;
    if (rx[31:0] !== 32'h0 || busy !== 1'b0) begin
      bad++; $display("FAIL fast_read_ignored got=%h/%b exp=0/0", rx[31:0], busy);
    end
`endif
    deselect();
  endtask

  task automatic test_load_collision();
    send_byte(8'h02);
    send_addr(24'h000060);
    for (int i = 7; i >= 1; i--) spi_bit(1'b1);
    load_en = 1'b1; load_addr = 8'h60; load_data = 8'h77;
    spi_bit(1'b1);
    load_en = 1'b0;
    deselect();
    send_byte(8'h03);
    send_addr(24'h000060);
    repeat (7) spi_bit(1'b0);
    total++;
    if (rx[7:0] !== 8'h77) begin bad++; $display("FAIL load_wins got=%h exp=77", rx[7:0]); end
    deselect();
  endtask

  initial begin
    rstn = 1'b0; spi_select = 1'b1; spi_clk_enable = 1'b0; spi_mosi = 1'b0;
    load_en = 1'b0; load_addr = 8'h00; load_data = 8'h00; rx = '0;
    test_reset();
    test_read();
    test_write_wrap();
    test_pause();
    test_abort_and_ignore();
    test_fast_read();
    test_load_collision();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
